// File: rtl/smaesh_shares_loader_pkg.sv
// Purpose: shared widths and block geometry for the masked-AES share loader.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package smaesh_shares_loader_pkg;

    localparam int SMAESH_WORD_W     = 32;
    localparam int SMAESH_BLOCK_BITS = 128;

    // Number of 32-bit words making up one full share vector (all shares of one block).
    function automatic int smaesh_words_per_block(input int shares);
        return shares * (SMAESH_BLOCK_BITS / SMAESH_WORD_W);
    endfunction

endpackage

// File: rtl/smaesh_shares_loader.sv
// Purpose: packs a 32-bit plaintext-share word stream into the 128*d-bit share vector for the AES core.
// Latency: last word accepted in cycle t -> out_valid in cycle t+1 when the output slot is free.
// Backpressure: one completed block is parked in the fill register; input stalls only while it is parked.
module smaesh_shares_loader
    import smaesh_shares_loader_pkg::*;
#(
    parameter int d = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_word_valid,
    output logic                           in_word_ready,
    input  logic [SMAESH_WORD_W-1:0]       in_word_data,
    input  logic                           in_word_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SMAESH_BLOCK_BITS*d-1:0] out_shares_data,
    output logic                           frame_err
);

    localparam int WPB = smaesh_words_per_block(d);
    localparam int CW  = $clog2(WPB);
    localparam int VW  = SMAESH_BLOCK_BITS * d;
    localparam logic [CW-1:0] CNT_LAST = CW'(WPB - 1);

    logic [CW-1:0] cnt;
    logic [VW-1:0] fill_q;
    logic [VW-1:0] fill_next;
    logic          fill_full;

    logic accept;
    logic at_end;
    logic blk_done;
    logic blk_bad;
    logic out_take;
    logic slot_free;

    // Ready is held low during reset so nothing is consumed before the datapath is clean.
    assign in_word_ready = ~fill_full & ~rst;

    assign accept    = in_word_valid & in_word_ready;
    assign at_end    = (cnt == CNT_LAST);
    assign blk_done  = accept & at_end & in_word_last;
    // A block is malformed when the last flag and the word position disagree.
    assign blk_bad   = accept & (in_word_last ^ at_end);
    assign out_take  = out_valid & out_ready;
    assign slot_free = ~out_valid | out_ready;

    // Fill vector including the word being accepted this cycle, so a completed block can bypass fill_q.
    always_comb begin
        fill_next = fill_q;
        fill_next[SMAESH_WORD_W*cnt +: SMAESH_WORD_W] = in_word_data;
    end

    // Input side: word counter, fill register, parked-block flag and framing-error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            fill_q    <= '0;
            fill_full <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= blk_bad;
            if (accept) begin
                fill_q <= fill_next;
                if (in_word_last || at_end) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            // Park the completed block when the output slot is still occupied; release it on handshake.
            if (blk_done && !slot_free) begin
                fill_full <= 1'b1;
            end else if (out_take && fill_full) begin
                fill_full <= 1'b0;
            end
        end
    end

    // Output side: share vector register and valid, zeroed whenever no block is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_shares_data <= '0;
        end else begin
            if (blk_done && slot_free) begin
                out_shares_data <= fill_next;
                out_valid       <= 1'b1;
            end else if (out_take) begin
                if (fill_full) begin
                    out_shares_data <= fill_q;
                end else begin
                    out_valid       <= 1'b0;
                    out_shares_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_smaesh_shares_loader.sv
// Purpose: directed self-checking bench for smaesh_shares_loader with an output scoreboard.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low across two blocks.
module tb_smaesh_shares_loader;

    localparam int D  = 2;
    localparam int VW = 128 * D;
    localparam int NW = 4 * D;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_word_valid;
    logic          in_word_ready;
    logic [31:0]   in_word_data;
    logic          in_word_last;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_shares_data;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int fe_cnt = 0;
    logic [VW-1:0] sb[$];

    smaesh_shares_loader #(.d(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_word_valid   (in_word_valid),
        .in_word_ready   (in_word_ready),
        .in_word_data    (in_word_data),
        .in_word_last    (in_word_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_shares_data (out_shares_data),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] mkvec(input logic [31:0] base);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < NW; k++) v[32*k +: 32] = base + 32'(k);
        return v;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one word and hold it until accepted; waits = number of sampling cycles spent.
    task automatic send_word(input logic [31:0] w, input logic last, output int waits);
        waits = 0;
        in_word_valid = 1'b1;
        in_word_data  = w;
        in_word_last  = last;
        while (1) begin
            @(negedge clk);
            waits++;
            if (in_word_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            if (waits > 200) begin
                checks++;
                errors++;
                $display("FAIL send_word_timeout observed ready=0 for %0d cycles expected accept", waits);
                @(posedge clk);
                #1;
                break;
            end
        end
        in_word_valid = 1'b0;
        in_word_last  = 1'b0;
    endtask

    // Send a well-formed block base+0..base+7 and record its expected vector.
    task automatic send_block(input logic [31:0] base, output int waits_total);
        int w;
        waits_total = 0;
        for (int k = 0; k < NW; k++) begin
            send_word(base + 32'(k), (k == NW - 1), w);
            waits_total += w;
        end
        sb.push_back(mkvec(base));
    endtask

    // Output monitor: every presented vector must equal the scoreboard head; idle bus must be zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output observed %h expected no output", out_shares_data);
                end else begin
                    check("out_vector", out_shares_data, sb[0]);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        hs_cnt++;
                    end
                end
            end else begin
                check("idle_data_zero", out_shares_data, '0);
            end
            if (frame_err) fe_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int hs0;
        int fe0;
        logic [VW-1:0] va;
        logic [VW-1:0] vb;

        rst = 1'b1;
        in_word_valid = 1'b0;
        in_word_data  = '0;
        in_word_last  = 1'b0;
        out_ready     = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_ready", VW'(in_word_ready), '0);
        check("rst_valid", VW'(out_valid), '0);
        check("rst_data", out_shares_data, '0);
        check("rst_frame_err", VW'(frame_err), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", VW'(in_word_ready), VW'(1));

        // Single block, core always ready: latency one cycle, one-cycle valid, bus returns to zero
        out_ready = 1'b1;
        send_block(32'h0000_0000, w);
        check("t1_latency_valid", VW'(out_valid), VW'(1));
        check("t1_layout", out_shares_data, mkvec(32'h0000_0000));
        @(posedge clk);
        #1;
        check("t1_valid_drop", VW'(out_valid), '0);
        check("t1_data_zero", out_shares_data, '0);

        // Backpressure: A held, B parked, input stalls, then A and B back-to-back
        out_ready = 1'b0;
        va = mkvec(32'hA000_0000);
        vb = mkvec(32'hB000_0000);
        send_block(32'hA000_0000, w);
        send_block(32'hB000_0000, w);
        check("t2_b_no_stall", VW'(w), VW'(NW));
        check("t2_ready_low", VW'(in_word_ready), '0);
        check("t2_hold_a", out_shares_data, va);
        repeat (3) @(posedge clk);
        #1;
        check("t2_still_stalled", VW'(in_word_ready), '0);
        check("t2_a_stable", out_shares_data, va);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_b_next", out_shares_data, vb);
        check("t2_b_valid", VW'(out_valid), VW'(1));
        check("t2_ready_back", VW'(in_word_ready), VW'(1));
        @(posedge clk);
        #1;
        check("t2_drained", VW'(out_valid), '0);

        // Continuous streaming of three blocks at full rate
        hs0 = hs_cnt;
        begin
            int tot;
            tot = 0;
            send_block(32'hC100_0000, w); tot += w;
            send_block(32'hC200_0000, w); tot += w;
            send_block(32'hC300_0000, w); tot += w;
            check("t3_no_stall", VW'(tot), VW'(3 * NW));
        end
        repeat (2) @(posedge clk);
        #1;
        check("t3_three_outputs", VW'(hs_cnt - hs0), VW'(3));
        check("t3_sb_empty", VW'(sb.size()), '0);

        // Early last flag on word 3: discarded, then a good block
        fe0 = fe_cnt;
        for (int k = 0; k < 4; k++) send_word(32'hDEAD_0000 + 32'(k), (k == 3), w);
        check("t4_frame_err", VW'(frame_err), VW'(1));
        check("t4_no_valid", VW'(out_valid), '0);
        @(posedge clk);
        #1;
        check("t4_pulse_one", VW'(frame_err), '0);
        send_block(32'hD000_0000, w);
        check("t4_good_after", out_shares_data, mkvec(32'hD000_0000));
        repeat (2) @(posedge clk);
        #1;
        check("t4_one_err", VW'(fe_cnt - fe0), VW'(1));

        // Missing last flag on word 7: discarded, then a good block
        fe0 = fe_cnt;
        for (int k = 0; k < NW; k++) send_word(32'hBAD0_0000 + 32'(k), 1'b0, w);
        check("t5_frame_err", VW'(frame_err), VW'(1));
        check("t5_no_valid", VW'(out_valid), '0);
        send_block(32'h5000_0000, w);
        check("t5_good_after", out_shares_data, mkvec(32'h5000_0000));
        repeat (2) @(posedge clk);
        #1;
        check("t5_one_err", VW'(fe_cnt - fe0), VW'(1));
        check("t5_sb_empty", VW'(sb.size()), '0);

        // Async reset while a vector is held and a frame error is pulsing
        out_ready = 1'b0;
        send_block(32'hE000_0000, w);
        send_word(32'hF000_0000, 1'b0, w);
        send_word(32'hF000_0001, 1'b1, w);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("t6_rst_valid", VW'(out_valid), '0);
        check("t6_rst_data", out_shares_data, '0);
        check("t6_rst_frame_err", VW'(frame_err), '0);
        check("t6_rst_ready", VW'(in_word_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Async reset mid-block: partial words must be dropped and counting restart at word 0
        for (int k = 0; k < 3; k++) send_word(32'h7700_0000 + 32'(k), 1'b0, w);
        #3;
        rst = 1'b1;
        #1;
        check("t7_rst_valid", VW'(out_valid), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fe0 = fe_cnt;
        send_block(32'h6000_0000, w);
        check("t7_valid", VW'(out_valid), VW'(1));
        check("t7_data", out_shares_data, mkvec(32'h6000_0000));
        repeat (2) @(posedge clk);
        #1;
        check("t7_no_err", VW'(fe_cnt - fe0), '0);
        check("final_sb_empty", VW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
